systolic_pe_dbuf: RTL and testbench
===================================

// Module: systolic_pe_dbuf
// PURPOSE
//  Weight-stationary systolic MAC cell with a double-buffered weight: shadow reg fed by a column shift chain, active reg used by the MAC.
//  Next-weight tile streams in while the current tile computes; one-cycle swap promotes it.
//  Registered A pass-through (east) and psum (south) for tiling into an R x C array.
//  Signed/unsigned operands and accumulator width are parametrised.
// PARAMETERS
//  DATAWIDTH  8              operand width (A and weight)
//  ACCWIDTH   3*DATAWIDTH    partial-sum width; must be >= 2*DATAWIDTH
//  SIGNED     1              1: two's-complement operands/psum; 0: unsigned
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous active-low reset
//  wt_shift_en  in   1          shift weight chain: shadow <= wt_in
//  wt_in        in   DATAWIDTH  weight from PE above (or array edge)
//  wt_out       out  DATAWIDTH  shadow weight to PE below (registered)
//  wt_swap      in   1          promote shadow -> active
//  wt_swap_out  out  1          wt_swap delayed 1 cycle, for skewed swap across array
//  valid_in     in   1          a_in/psum_in valid this cycle
//  a_in         in   DATAWIDTH  activation from west
//  psum_in      in   ACCWIDTH   partial sum from north
//  valid_out    out  1          a_out/psum_out updated last cycle
//  a_out        out  DATAWIDTH  registered a_in to east
//  psum_out     out  ACCWIDTH   registered partial sum to south
//  ovf_clr      in   1          clear sticky overflow flag
//  ovf_sticky   out  1          sticky saturation flag (0 when PE_SAT_EN off)
// BEHAVIOUR
//  Reset (async, any time, mid-operation included): w_act, w_shd, wt_out, wt_swap_out,
//   valid_out, a_out, psum_out, ovf_sticky all 0. No partial state survives.
//  Weight path: wt_shift_en=1 -> w_shd <= wt_in; wt_out always = w_shd (1-cycle/hop chain).
//   wt_swap=1 -> w_act <= w_shd (pre-edge value). Swap + shift same cycle: w_act gets OLD
//   shadow, w_shd gets wt_in. wt_swap_out <= wt_swap every cycle.
//  MAC: valid_in=1 -> psum_out <= ext(a_in)*ext(w_act) + psum_in; a_out <= a_in;
//   valid_out <= 1. Uses w_act before edge: swap in same cycle affects next beat only.
//  valid_in=0 -> psum_out, a_out hold; valid_out <= 0. Latency 1 cycle, throughput 1/cycle.
//  Width: product is 2*DATAWIDTH, sign-extended (SIGNED=1) or zero-extended (SIGNED=0)
//   to ACCWIDTH; sum computed at ACCWIDTH+1 and then wrapped or saturated (see below).
//  ovf_clr and saturation event same cycle: set wins.
// CONFIGURATION
//  Macro PE_SAT_EN defined: sum clamped to ACCWIDTH max/min (signed range if SIGNED=1,
//   else [0, 2^ACCWIDTH-1]); ovf_sticky <= 1 on any clamp, cleared only by ovf_clr/reset.
//  Undefined: modulo-2^ACCWIDTH wrap; ovf_sticky tied 0; ovf_clr ignored.
// STRUCTURE
//  Package systolic_pkg: default DATAWIDTH/ACCWIDTH localparams, function acc_ext()
//   (sign/zero extend), function sat_add() (ACCWIDTH clamp, returns ovf bit).
//  One sub-module: pe_mac (combinational multiply/extend/add/saturate; no state).
//  Top holds all registers: weight double buffer, swap delay, output pipeline, flag.
// TESTING (DATAWIDTH=8, ACCWIDTH=24)
//  Reset mid-stream with valid_in=1 -> all outputs 0 same cycle, w_act=0 after release.
//  Shift 5, swap, then valid a=3 psum=10 -> next cycle psum_out=25, a_out=3, valid_out=1.
//  w_shd=5, wt_in=7, shift+swap together -> w_act=5, wt_out=7; valid beat in swap cycle uses old w_act.
//  SIGNED=1, w=0xFE, a=100, psum=0 -> 0xFFFF38 (-200); SIGNED=0 same inputs -> 0x006338 (25400).
//  psum_in=0x7FFFFF, a=1, w=1: PE_SAT_EN -> 0x7FFFFF, ovf_sticky=1 (holds until ovf_clr);
//   without macro -> 0x800000, ovf_sticky=0.
//  valid_in=0 for 3 cycles after a beat -> psum_out/a_out hold, valid_out=0; wt_swap_out tracks wt_swap +1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared defaults and width helpers for the systolic PE: operand extension and
// clamped/wrapped accumulation evaluated on a 64-bit working width.
package systolic_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_ACCWIDTH  = 3 * DEF_DATAWIDTH;
  localparam int MAXW          = 64;

  typedef logic [MAXW-1:0] wide_t;

  function automatic wide_t lo_mask(input int w);
    return (w >= MAXW) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
  endfunction

  // Sign- or zero-extend the low w bits of v to the full working width.
  function automatic wide_t acc_ext(input wide_t v, input int w, input bit sgn);
    wide_t m;
    wide_t r;
    m = lo_mask(w);
    r = v & m;
    if (sgn && v[w-1]) r = r | ~m;
    return r;
  endfunction

  // Add two extended operands and fold the result back into w bits, either
  // clamping to the representable range or wrapping; ovf flags an out-of-range sum.
  function automatic wide_t sat_add(input wide_t x, input wide_t y, input int w,
                                    input bit sgn, input bit sat_en, output logic ovf);
    logic signed [MAXW-1:0] s;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    s = signed'(x + y);
    if (sgn) begin
      hi = signed'(lo_mask(w - 1));
      lo = signed'(~lo_mask(w - 1));
    end else begin
      hi = signed'(lo_mask(w));
      lo = '0;
    end
    ovf = 1'b0;
    if (s > hi) begin
      ovf = 1'b1;
      if (sat_en) s = hi;
    end else if (s < lo) begin
      ovf = 1'b1;
      if (sat_en) s = lo;
    end
    return wide_t'(s) & lo_mask(w);
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply / extend / accumulate for one systolic PE; no state.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ACCWIDTH  = DEF_ACCWIDTH,
  parameter int SIGNED    = 1,
  parameter bit SAT_EN    = 1'b0
) (
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_w,
  input  logic [ACCWIDTH-1:0]  i_psum,
  output logic [ACCWIDTH-1:0]  o_sum,
  output logic                 o_ovf
);

  localparam bit SGN = (SIGNED != 0);

  logic [2*DATAWIDTH-1:0] w_a_x;
  logic [2*DATAWIDTH-1:0] w_w_x;
  logic [2*DATAWIDTH-1:0] w_prod;
  wide_t                  w_wide;
  logic                   w_ovf;
  logic                   w_unused_hi;

  // Extending to the product width first makes a plain low-half multiply exact.
  if (SGN) begin : g_sext
    assign w_a_x = {{DATAWIDTH{i_a[DATAWIDTH-1]}}, i_a};
    assign w_w_x = {{DATAWIDTH{i_w[DATAWIDTH-1]}}, i_w};
  end else begin : g_zext
    assign w_a_x = {{DATAWIDTH{1'b0}}, i_a};
    assign w_w_x = {{DATAWIDTH{1'b0}}, i_w};
  end

  assign w_prod = w_a_x * w_w_x;

  always_comb begin
    w_ovf  = 1'b0;
    w_wide = sat_add(acc_ext(wide_t'(w_prod), 2*DATAWIDTH, SGN),
                     acc_ext(wide_t'(i_psum), ACCWIDTH, SGN),
                     ACCWIDTH, SGN, SAT_EN, w_ovf);
  end

  assign o_sum       = w_wide[ACCWIDTH-1:0];
  assign o_ovf       = w_ovf;
  assign w_unused_hi = ^w_wide[MAXW-1:ACCWIDTH];

endmodule

// File: rtl/systolic_pe_dbuf.sv
// Weight-stationary systolic MAC cell with shadow/active weight double buffer.
// Optional macro PE_SAT_EN: saturating accumulate with sticky overflow flag.
module systolic_pe_dbuf
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ACCWIDTH  = 3 * DATAWIDTH,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wt_shift_en,
  input  logic [DATAWIDTH-1:0] wt_in,
  output logic [DATAWIDTH-1:0] wt_out,
  input  logic                 wt_swap,
  output logic                 wt_swap_out,
  input  logic                 valid_in,
  input  logic [DATAWIDTH-1:0] a_in,
  input  logic [ACCWIDTH-1:0]  psum_in,
  output logic                 valid_out,
  output logic [DATAWIDTH-1:0] a_out,
  output logic [ACCWIDTH-1:0]  psum_out,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);

`ifdef PE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [DATAWIDTH-1:0] r_w_act;
  logic [DATAWIDTH-1:0] r_w_shd;
  logic                 r_swap_d;
  logic                 r_vld;
  logic [DATAWIDTH-1:0] r_a;
  logic [ACCWIDTH-1:0]  r_psum;
  logic [ACCWIDTH-1:0]  w_sum;
  logic                 w_ovf;

  pe_mac #(
    .DATAWIDTH (DATAWIDTH),
    .ACCWIDTH  (ACCWIDTH),
    .SIGNED    (SIGNED),
    .SAT_EN    (SAT_EN)
  ) u_mac (
    .i_a    (a_in),
    .i_w    (r_w_act),
    .i_psum (psum_in),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  // Swap reads the pre-edge shadow, so a simultaneous shift loads the next tile safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_act  <= '0;
      r_w_shd  <= '0;
      r_swap_d <= 1'b0;
      r_vld    <= 1'b0;
      r_a      <= '0;
      r_psum   <= '0;
    end else begin
      if (wt_swap)     r_w_act <= r_w_shd;
      if (wt_shift_en) r_w_shd <= wt_in;
      r_swap_d <= wt_swap;
      r_vld    <= valid_in;
      if (valid_in) begin
        r_a    <= a_in;
        r_psum <= w_sum;
      end
    end
  end

`ifdef PE_SAT_EN
  logic r_ovf;

  // A clamp in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ovf <= 1'b0;
    else if (valid_in && w_ovf) r_ovf <= 1'b1;
    else if (ovf_clr)          r_ovf <= 1'b0;
  end

  assign ovf_sticky = r_ovf;
`else
  logic w_unused_ovf;

  assign w_unused_ovf = ^{ovf_clr, w_ovf};
  assign ovf_sticky   = 1'b0;
`endif

  assign wt_out      = r_w_shd;
  assign wt_swap_out = r_swap_d;
  assign valid_out   = r_vld;
  assign a_out       = r_a;
  assign psum_out    = r_psum;

endmodule

// File: tb/tb_systolic_pe_dbuf.sv
// Self-checking bench for systolic_pe_dbuf: signed and unsigned instances share stimulus,
// a queue holds expected beats from drive time until the output cycle.
module tb_systolic_pe_dbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wt_shift_en = 1'b0;
  logic [7:0]  wt_in = '0;
  logic        wt_swap = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  a_in = '0;
  logic [23:0] psum_in = '0;
  logic        ovf_clr = 1'b0;

  logic [7:0]  wt_out_s, wt_out_u, a_out_s, a_out_u;
  logic        wt_swap_out_s, wt_swap_out_u, valid_out_s, valid_out_u;
  logic [23:0] psum_out_s, psum_out_u;
  logic        ovf_sticky_s, ovf_sticky_u;

  always #5 clk = ~clk;

  systolic_pe_dbuf #(.DATAWIDTH(8), .ACCWIDTH(24), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .wt_shift_en(wt_shift_en), .wt_in(wt_in), .wt_out(wt_out_s),
    .wt_swap(wt_swap), .wt_swap_out(wt_swap_out_s), .valid_in(valid_in), .a_in(a_in),
    .psum_in(psum_in), .valid_out(valid_out_s), .a_out(a_out_s), .psum_out(psum_out_s),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky_s));

  systolic_pe_dbuf #(.DATAWIDTH(8), .ACCWIDTH(24), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .wt_shift_en(wt_shift_en), .wt_in(wt_in), .wt_out(wt_out_u),
    .wt_swap(wt_swap), .wt_swap_out(wt_swap_out_u), .valid_in(valid_in), .a_in(a_in),
    .psum_in(psum_in), .valid_out(valid_out_u), .a_out(a_out_u), .psum_out(psum_out_u),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky_u));

  typedef struct {
    logic [23:0] ps;
    logic [23:0] pu;
    logic [7:0]  a;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  m_act = '0, m_shd = '0, m_a = '0;
  logic [23:0] m_ps = '0, m_pu = '0;
  logic        m_os = 1'b0, m_ou = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_sum(input logic [7:0] a, input logic [7:0] w,
                                          input logic [23:0] p, input bit sgn, output bit ovf);
    longint av, wv, pv, s, hi, lo, one;
    logic [63:0] sv;
    one = 1;
    av  = sgn ? longint'($signed(a)) : longint'(a);
    wv  = sgn ? longint'($signed(w)) : longint'(w);
    pv  = sgn ? longint'($signed(p)) : longint'(p);
    s   = av * wv + pv;
    hi  = sgn ? (one <<< 23) - 1 : (one <<< 24) - 1;
    lo  = sgn ? -(one <<< 23) : 0;
    ovf = (s > hi) || (s < lo);
`ifdef PE_SAT_EN
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`else
    ovf = 1'b0;
`endif
    sv = 64'(s);
    return sv[23:0];
  endfunction

  task automatic step(input logic sh, input logic [7:0] wi, input logic sw, input logic v,
                      input logic [7:0] a, input logic [23:0] p, input logic clr);
    exp_t e;
    bit   os, ou;
    @(negedge clk);
    wt_shift_en = sh; wt_in = wi; wt_swap = sw;
    valid_in = v; a_in = a; psum_in = p; ovf_clr = clr;
    os = 1'b0; ou = 1'b0;
    if (v) begin
      e.ps = ref_sum(a, m_act, p, 1'b1, os);
      e.pu = ref_sum(a, m_act, p, 1'b0, ou);
      e.a  = a;
      sb_q.push_back(e);
    end
    m_os = (v && os) ? 1'b1 : (clr ? 1'b0 : m_os);
    m_ou = (v && ou) ? 1'b1 : (clr ? 1'b0 : m_ou);
`ifndef PE_SAT_EN
    m_os = 1'b0; m_ou = 1'b0;
`endif
    if (sw) m_act = m_shd;
    if (sh) m_shd = wi;
    @(posedge clk);
    #1;
    chk("valid_out_s", 32'(valid_out_s), 32'(v));
    chk("valid_out_u", 32'(valid_out_u), 32'(v));
    if (v) begin
      chk("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        m_ps = e.ps; m_pu = e.pu; m_a = e.a;
      end
    end
    chk("psum_out_s", 32'(psum_out_s), 32'(m_ps));
    chk("psum_out_u", 32'(psum_out_u), 32'(m_pu));
    chk("a_out", 32'(a_out_s), 32'(m_a));
    chk("wt_out", 32'(wt_out_s), 32'(m_shd));
    chk("wt_swap_out", 32'(wt_swap_out_s), 32'(sw));
    chk("ovf_sticky_s", 32'(ovf_sticky_s), 32'(m_os));
    chk("ovf_sticky_u", 32'(ovf_sticky_u), 32'(m_ou));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_psum_s"}, 32'(psum_out_s), 32'd0);
    chk({tag, "_psum_u"}, 32'(psum_out_u), 32'd0);
    chk({tag, "_a_out"}, 32'(a_out_s), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out_s), 32'd0);
    chk({tag, "_wt_out"}, 32'(wt_out_s), 32'd0);
    chk({tag, "_swap_out"}, 32'(wt_swap_out_s), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_sticky_s), 32'd0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    wt_shift_en = 1'b1; wt_in = 8'h33; wt_swap = 1'b1;
    valid_in = 1'b1; a_in = 8'h55; psum_in = 24'h000123; ovf_clr = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    sb_q.delete();
    m_act = '0; m_shd = '0; m_a = '0; m_ps = '0; m_pu = '0; m_os = 1'b0; m_ou = 1'b0;
    @(negedge clk);
    wt_shift_en = 1'b0; wt_swap = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // load 5, promote, then one beat
    step(1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 24'd10, 1'b0);
    chk("mac_25", 32'(psum_out_s), 32'd25);
    chk("a_out_3", 32'(a_out_s), 32'd3);

    // shift+swap together with a beat in the swap cycle
    step(1'b1, 8'd2, 1'b0, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b1, 8'd7, 1'b1, 1'b1, 8'd4, 24'd0, 1'b0);
    chk("swap_beat_old_wact", 32'(psum_out_s), 32'd8);
    chk("wt_out_7", 32'(wt_out_s), 32'd7);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 24'd0, 1'b0);
    chk("new_wact_5", 32'(psum_out_s), 32'd20);

    // three idle cycles: outputs hold, swap echo follows one cycle late
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 24'd99, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd9, 24'd99, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 24'd99, 1'b0);
    chk("hold_psum", 32'(psum_out_s), 32'd20);
    chk("hold_a", 32'(a_out_s), 32'd4);

    // signed vs unsigned interpretation of 0xFE
    step(1'b1, 8'hFE, 1'b0, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd100, 24'd0, 1'b0);
    chk("signed_neg200", 32'(psum_out_s), 32'h00FFFF38);
    chk("unsigned_25400", 32'(psum_out_u), 32'h00006338);

    // positive overflow boundary
    step(1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 24'h7FFFFF, 1'b0);
`ifdef PE_SAT_EN
    chk("sat_max", 32'(psum_out_s), 32'h007FFFFF);
    chk("sat_flag", 32'(ovf_sticky_s), 32'd1);
`else
    chk("wrap_min", 32'(psum_out_s), 32'h00800000);
    chk("no_flag", 32'(ovf_sticky_s), 32'd0);
`endif
    chk("unsigned_no_ovf", 32'(psum_out_u), 32'h00800000);
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 24'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 24'd3, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 24'd0, 1'b1);
    chk("flag_cleared", 32'(ovf_sticky_s), 32'd0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 24'h7FFFFF, 1'b1);
`ifdef PE_SAT_EN
    chk("set_beats_clr", 32'(ovf_sticky_s), 32'd1);
`endif
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 24'd0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           8'($urandom), 24'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    mid_reset();
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 24'd5, 1'b0);
    chk("post_rst_wact0", 32'(psum_out_s), 32'd5);
    step(1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 24'd0, 1'b0);
    chk("post_rst_shd0", 32'(psum_out_s), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
